// File: rtl/hyp_cordic_vectoring.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hyp_cordic_vectoring                                       |
// | Description : Iterative hyperbolic CORDIC, vectoring mode. Drives y to   |
// |               zero with one micro-rotation per clock and returns         |
// |               theta = atanh(y/x) and the (gain-scaled) magnitude.        |
// |               Shift sequence 1,2,3,4,4,5..13,13,14 (16 steps).           |
// |               Optional build macro GAIN_COMP_EN adds a 1/K_h multiply    |
// |               cycle so mag_out = sqrt(x^2 - y^2).                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hyp_cordic_vectoring #(
    parameter int N_ITER = 14,
    parameter int GUARD  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] theta_out,
    output logic signed [15:0] mag_out,
    output logic               err_out
);

    localparam int c_W      = 16 + GUARD;
    localparam int c_STEPS  = N_ITER + ((N_ITER >= 4) ? 1 : 0) + ((N_ITER >= 13) ? 1 : 0);
    localparam int c_CW     = $clog2(c_STEPS + 1);
    localparam int c_SW     = $clog2(N_ITER + 2);
    // The angle table below is written at Q.18 (GUARD = 4) and rescaled here.
    localparam int c_UP     = (GUARD >= 4) ? (GUARD - 4) : 0;
    localparam int c_DN     = (GUARD < 4) ? (4 - GUARD) : 0;
    localparam int c_DN_RND = (1 << c_DN) >> 1;
    localparam int c_RND    = (1 << GUARD) >> 1;
    localparam logic signed [c_W:0] c_MAXV = (c_W+1)'(32767);
    localparam logic signed [c_W:0] c_MINV = -(c_W+1)'(32768);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_GAIN = 2'd3
    } t_state;

    t_state                  r_state;
    t_state                  w_state_nx;
    logic signed [c_W-1:0]   r_x;
    logic signed [c_W-1:0]   r_y;
    logic signed [c_W-1:0]   r_z;
    logic [c_CW-1:0]         r_iter;
    logic [c_SW-1:0]         r_shift;
    logic                    r_rep;
    logic                    r_err;
    logic signed [15:0]      r_theta;
    logic signed [15:0]      r_mag;

    logic                    w_accept;
    logic                    w_last;
    logic                    w_in_err;
    logic signed [15:0]      w_abs_y;
    logic                    w_y_neg;
    logic signed [c_W-1:0]   w_xs;
    logic signed [c_W-1:0]   w_ys;
    logic signed [c_W-1:0]   w_atanh;
    logic signed [c_W-1:0]   w_x_nx;
    logic signed [c_W-1:0]   w_y_nx;
    logic signed [c_W-1:0]   w_z_nx;

    // round(atanh(2^-i) * 2^18), rescaled to Q.(14+GUARD); beyond i=14 atanh(2^-i) ~= 2^-i
    function automatic logic signed [c_W-1:0] f_atanh(input logic [c_SW-1:0] i_idx);
        int v;
        case (int'(i_idx))
            1:       v = 143997;
            2:       v = 66955;
            3:       v = 32940;
            4:       v = 16405;
            5:       v = 8195;
            6:       v = 4096;
            7:       v = 2048;
            8:       v = 1024;
            9:       v = 512;
            10:      v = 256;
            11:      v = 128;
            12:      v = 64;
            13:      v = 32;
            14:      v = 16;
            default: v = 262144 >>> int'(i_idx);
        endcase
        v = v <<< c_UP;
        v = (v + c_DN_RND) >>> c_DN;
        return c_W'(v);
    endfunction

    // Drop the guard bits with round-half-up, then clamp to the 16-bit range
    function automatic logic signed [15:0] f_round(input logic signed [c_W-1:0] i_v);
        logic signed [c_W:0] s;
        s = ($signed({i_v[c_W-1], i_v}) + $signed((c_W+1)'(c_RND))) >>> GUARD;
        if (s > c_MAXV) begin
            return 16'sh7fff;
        end else if (s < c_MINV) begin
            return -16'sh8000;
        end
        return s[15:0];
    endfunction

    // -32768 has no positive counterpart, so its magnitude saturates to 32767
    assign w_abs_y  = (y_in == -16'sh8000) ? 16'sh7fff : (y_in[15] ? -y_in : y_in);
    assign w_in_err = (x_in <= 16'sh0000) || (w_abs_y >= x_in);
    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_iter == c_CW'(c_STEPS - 1));

    // One simultaneous micro-rotation; direction chosen by the sign of y
    assign w_y_neg = r_y[c_W-1];
    assign w_xs    = r_x >>> r_shift;
    assign w_ys    = r_y >>> r_shift;
    assign w_atanh = f_atanh(r_shift);
    assign w_x_nx  = w_y_neg ? (r_x + w_ys) : (r_x - w_ys);
    assign w_y_nx  = w_y_neg ? (r_y + w_xs) : (r_y - w_xs);
    assign w_z_nx  = w_y_neg ? (r_z - w_atanh) : (r_z + w_atanh);

`ifdef GAIN_COMP_EN
    localparam logic signed [16:0]   c_INV_KH  = 17'sd19784;
    localparam int                   c_PSH     = 14 + GUARD;
    localparam logic signed [c_W+16:0] c_P_RND = (c_W+17)'(1) <<< (c_PSH - 1);
    localparam logic signed [c_W+16:0] c_P_MAX = (c_W+17)'(32767);
    localparam logic signed [c_W+16:0] c_P_MIN = -(c_W+17)'(32768);
    logic signed [c_W+16:0] w_prod;
    logic signed [c_W+16:0] w_prod_r;
    logic signed [15:0]     w_mag_comp;

    // Undo the CORDIC gain: x * (1/K_h), rounded straight back to Q2.14
    assign w_prod   = r_x * c_INV_KH;
    assign w_prod_r = (w_prod + c_P_RND) >>> c_PSH;
    assign w_mag_comp = (w_prod_r > c_P_MAX) ? 16'sh7fff :
                        (w_prod_r < c_P_MIN) ? -16'sh8000 : w_prod_r[15:0];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_nx = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                // An out-of-domain operand spends a single cycle here with the
                // datapath frozen, so its result appears one edge after accept.
                if (r_err) begin
                    w_state_nx = S_DONE;
                end else if (w_last) begin
`ifdef GAIN_COMP_EN
                    w_state_nx = S_GAIN;
`else
                    w_state_nx = S_DONE;
`endif
                end
            end
            S_GAIN: begin
                w_state_nx = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Operand load, iteration datapath and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_shift <= c_SW'(1);
            r_rep   <= 1'b0;
            r_err   <= 1'b0;
            r_theta <= '0;
            r_mag   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x     <= {x_in, {GUARD{1'b0}}};
                        r_y     <= {y_in, {GUARD{1'b0}}};
                        r_z     <= '0;
                        r_iter  <= '0;
                        r_shift <= c_SW'(1);
                        r_rep   <= 1'b0;
                        r_err   <= w_in_err;
                        r_theta <= '0;
                        r_mag   <= '0;
                    end
                end
                S_RUN: begin
                    if (!r_err) begin
                        r_x    <= w_x_nx;
                        r_y    <= w_y_nx;
                        r_z    <= w_z_nx;
                        r_iter <= r_iter + c_CW'(1);
                        // Shifts 4 and 13 are executed twice to keep convergence
                        if (((r_shift == c_SW'(4)) || (r_shift == c_SW'(13))) && !r_rep) begin
                            r_rep <= 1'b1;
                        end else begin
                            r_rep   <= 1'b0;
                            r_shift <= r_shift + c_SW'(1);
                        end
                        if (w_last) begin
                            r_theta <= f_round(w_z_nx);
`ifndef GAIN_COMP_EN
                            r_mag   <= f_round(w_x_nx);
`endif
                        end
                    end
                end
`ifdef GAIN_COMP_EN
                S_GAIN: begin
                    r_mag <= w_mag_comp;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign theta_out = r_theta;
    assign mag_out   = r_mag;
    assign err_out   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hyp_cordic_vectoring.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hyp_cordic_vectoring                                    |
// | Description : Directed self-checking bench for hyp_cordic_vectoring     |
// |               (default build, no gain compensation).                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_hyp_cordic_vectoring;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] theta_out;
    logic signed [15:0] mag_out;
    logic               err_out;

    int n_cmp;
    int n_mis;
    int lat;
    int seen;

    hyp_cordic_vectoring dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .theta_out (theta_out),
        .mag_out   (mag_out),
        .err_out   (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        n_cmp++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d+-%0d", tag, obs, exp, tol);
        end
    endtask

    // Present one operand pair for exactly one accept edge
    task automatic start(input int x, input int y);
        x_in     = 16'(x);
        y_in     = 16'(y);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid rises (bounded)
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_theta", int'(theta_out), 0);
        chk("rst_mag", int'(mag_out), 0);
        chk("rst_err", int'(err_out), 0);
        rst_n = 1'b1;
        tick();

        // theta = +0.25
        start(16899, 4139);
        chk("t1_in_ready_busy", int'(in_ready), 0);
        wait_valid(lat);
        chk("t1_latency", lat, 16);
        chk_tol("t1_theta", int'(theta_out), 4096, 3);
        chk_tol("t1_mag", int'(mag_out), 13569, 4);
        chk("t1_err", int'(err_out), 0);
        handshake();
        chk("t1_out_valid_drop", int'(out_valid), 0);
        chk("t1_in_ready_back", int'(in_ready), 1);

        // theta = +0.5, exact latency
        start(18475, 8538);
        wait_valid(lat);
        chk("t2_latency", lat, 16);
        chk_tol("t2_theta", int'(theta_out), 8192, 3);
        chk_tol("t2_mag", int'(mag_out), 13569, 4);
        handshake();

        // theta = -0.25, then hold DONE for 5 cycles
        start(16899, -4139);
        wait_valid(lat);
        chk("t3_latency", lat, 16);
        chk_tol("t3_theta", int'(theta_out), -4096, 3);
        chk_tol("t3_mag", int'(mag_out), 13569, 4);
        chk("t3_err", int'(err_out), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", int'(out_valid), 1);
            chk("t5_hold_in_ready", int'(in_ready), 0);
            chk_tol("t5_hold_theta", int'(theta_out), -4096, 3);
            chk_tol("t5_hold_mag", int'(mag_out), 13569, 4);
        end
        handshake();
        chk("t5_out_valid_drop", int'(out_valid), 0);
        chk("t5_in_ready_back", int'(in_ready), 1);

        // |y| == x is outside the domain
        start(16384, 16384);
        chk("t4_not_yet_valid", int'(out_valid), 0);
        wait_valid(lat);
        chk("t4_latency", lat, 1);
        chk("t4_err", int'(err_out), 1);
        chk("t4_theta", int'(theta_out), 0);
        chk("t4_mag", int'(mag_out), 0);
        handshake();

        // y = -32768 saturates to |y| = 32767 >= x
        start(32767, -32768);
        wait_valid(lat);
        chk("b1_latency", lat, 1);
        chk("b1_err", int'(err_out), 1);
        handshake();

        // x = 0 and negative x are rejected
        start(0, 0);
        wait_valid(lat);
        chk("b2_err_x0", int'(err_out), 1);
        handshake();
        start(-100, 0);
        wait_valid(lat);
        chk("b3_err_xneg", int'(err_out), 1);
        chk("b3_mag", int'(mag_out), 0);
        handshake();

        // Largest x with y = 0: theta 0, mag = 32767*K_h
        start(32767, 0);
        wait_valid(lat);
        chk("b4_latency", lat, 16);
        chk("b4_err", int'(err_out), 0);
        chk_tol("b4_theta", int'(theta_out), 0, 3);
        chk_tol("b4_mag", int'(mag_out), 27136, 4);
        handshake();

        // Reset in the middle of RUN discards the operation
        start(18475, 8538);
        tick();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_in_ready", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("t6_no_stale_result", seen, 0);
        start(16899, 4139);
        wait_valid(lat);
        chk("t6_new_latency", lat, 16);
        chk_tol("t6_new_theta", int'(theta_out), 4096, 3);
        chk("t6_new_err", int'(err_out), 0);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
